// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default datapath widths, opcode field
// location and the opcode encodings consumed by the control unit.
package cpu_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_INSTR_W = 32;
    localparam int OPCODE_W    = 5;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ALU    = 5'b00000,
        OP_ALUI   = 5'b00001,
        OP_LOAD   = 5'b00010,
        OP_STORE  = 5'b00011,
        OP_BRANCH = 5'b00100,
        OP_JAL    = 5'b00101,
        OP_JALR   = 5'b00110,
        OP_LUI    = 5'b00111,
        OP_SYSTEM = 5'b10101
    } opcode_e;

    typedef enum logic [0:0] {
        FS_RESET_WAIT = 1'b0,
        FS_RUN        = 1'b1
    } fetch_state_e;

    // The opcode occupies the top OPCODE_W bits of the instruction word.
    function automatic int opcode_msb(input int instr_w);
        return instr_w - 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with registered storage and a combinational head.
// Clear overrides push and pop; the head reads zero while empty.
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             empty_s;
    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Next-state for storage, pointers and occupancy; a full FIFO may push only alongside a pop.
    always_comb begin
        empty_s   = (count_q == {CNT_W{1'b0}});
        full_s    = (count_q == CNT_W'(DEPTH));
        do_pop_s  = pop && !empty_s;
        do_push_s = push && (!full_s || do_pop_s);
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (clear) begin
            rd_ptr_d = {PTR_W{1'b0}};
            wr_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_valid = !empty_s;
    assign head_data  = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/fetch_stage_chk.sv
// Protocol checks for the fetch stage: responses only against issued
// requests, and in-flight/drop accounting never beyond the credit limit.
module fetch_stage_chk #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input logic             clk,
    input logic             rst,
    input logic             rsp_valid,
    input logic [CNT_W-1:0] outstanding,
    input logic [CNT_W-1:0] drop_cnt
);

    a_rsp_needs_request: assert property (@(posedge clk) disable iff (rst)
        !(rsp_valid && (outstanding == {CNT_W{1'b0}})));

    a_outstanding_bound: assert property (@(posedge clk) disable iff (rst)
        outstanding <= CNT_W'(DEPTH));

    a_drop_bound: assert property (@(posedge clk) disable iff (rst)
        drop_cnt <= outstanding);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, credit-limited in-order memory requests,
// PC tag tracking, redirect with stale-response discard, prefetch FIFO to decode.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int               ADDR_W   = DEF_ADDR_W,
    parameter int               INSTR_W  = DEF_INSTR_W,
    parameter int               DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ready,
    input  logic                imem_rvalid,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                redirect_en,
    input  logic [ADDR_W-1:0]   redirect_pc,
    input  logic                stall,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   instr_pc,
    output logic [OPCODE_W-1:0] opcode
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int SUM_W  = CNT_W + 1;
    localparam int OP_MSB = opcode_msb(INSTR_W);

    fetch_state_e              state_q;
    fetch_state_e              state_d;
    logic [ADDR_W-1:0]         pc_q;
    logic [ADDR_W-1:0]         pc_d;
    logic [CNT_W-1:0]          drop_q;
    logic [CNT_W-1:0]          drop_d;

    logic [CNT_W-1:0]          occ_s;
    logic [CNT_W-1:0]          out_s;
    logic [CNT_W-1:0]          out_after_s;
    logic [SUM_W-1:0]          credit_sum_s;
    logic                      req_s;
    logic                      issue_s;
    logic                      resp_s;
    logic                      discard_s;
    logic                      push_s;
    logic                      pop_s;
    logic                      tag_valid_s;
    logic [ADDR_W-1:0]         tag_s;
    logic                      head_valid_s;
    logic [ADDR_W+INSTR_W-1:0] head_s;
    logic [ADDR_W-1:0]         redirect_tgt_s;
    logic                      unused_s;

    // Request/response bookkeeping; a redirect turns this cycle's response into a discard.
    always_comb begin
        pop_s          = head_valid_s && !stall;
        credit_sum_s   = SUM_W'(occ_s) + SUM_W'(out_s) - SUM_W'(pop_s);
        issue_s        = req_s && imem_ready;
        resp_s         = imem_rvalid && tag_valid_s;
        discard_s      = resp_s && (redirect_en || (drop_q != {CNT_W{1'b0}}));
        push_s         = resp_s && !discard_s;
        out_after_s    = out_s + CNT_W'(issue_s) - CNT_W'(resp_s);
        redirect_tgt_s = {redirect_pc[ADDR_W-1:2], 2'b00};
    end

    // Two-state sequencer: one idle cycle out of reset, then credit-limited requests.
    always_comb begin
        state_d = state_q;
        req_s   = 1'b0;
        case (state_q)
            FS_RESET_WAIT: begin
                state_d = FS_RUN;
                req_s   = 1'b0;
            end
            FS_RUN: begin
                state_d = FS_RUN;
                req_s   = (credit_sum_s < SUM_W'(DEPTH));
            end
            default: begin
                state_d = FS_RESET_WAIT;
                req_s   = 1'b0;
            end
        endcase
    end

    // PC and drop counter; words still in flight at a redirect become drops.
    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (redirect_en) begin
            pc_d   = redirect_tgt_s;
            drop_d = out_after_s;
        end else begin
            if (issue_s) begin
                pc_d = pc_q + ADDR_W'(3'd4);
            end else begin
                pc_d = pc_q;
            end
            if (resp_s && (drop_q != {CNT_W{1'b0}})) begin
                drop_d = drop_q - CNT_W'(1'b1);
            end else begin
                drop_d = drop_q;
            end
        end
    end

    // State, PC and drop registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FS_RESET_WAIT;
            pc_q    <= RESET_PC;
            drop_q  <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W)
    ) u_tag_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (1'b0),
        .push       (issue_s),
        .push_data  (pc_q),
        .pop        (resp_s),
        .head_valid (tag_valid_s),
        .head_data  (tag_s),
        .count      (out_s)
    );

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INSTR_W)
    ) u_instr_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (redirect_en),
        .push       (push_s),
        .push_data  ({tag_s, imem_rdata}),
        .pop        (pop_s),
        .head_valid (head_valid_s),
        .head_data  (head_s),
        .count      (occ_s)
    );

    fetch_stage_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .rsp_valid   (imem_rvalid),
        .outstanding (out_s),
        .drop_cnt    (drop_q)
    );

    assign unused_s    = ^redirect_pc[1:0];
    assign imem_req    = req_s;
    assign imem_addr   = pc_q;
    assign instr_valid = head_valid_s;
    assign instr_pc    = head_s[ADDR_W+INSTR_W-1:INSTR_W];
    assign instr       = head_s[INSTR_W-1:0];
    assign opcode      = head_s[OP_MSB -: OPCODE_W];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a fixed-latency in-order memory responder
// drives responses; every expected value below is worked out by hand.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [4:0]  opcode;

    int          checks   = 0;
    int          failures = 0;
    int          lat      = 1;
    int          cyc      = 0;
    int          due_q[$];
    logic [31:0] addr_q[$];

    fetch_stage #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .DEPTH    (2),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .opcode      (opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0300) return 32'hA800_0000;
        return ~a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: record an issue, cross the edge, present any response due this cycle.
    task automatic tick();
        #1;
        if (imem_req && imem_ready) begin
            due_q.push_back(cyc + lat);
            addr_q.push_back(imem_addr);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(addr_q[0]);
            void'(due_q.pop_front());
            void'(addr_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0000_0000;
        end
        #1;
    endtask

    task automatic release_rst();
        rst         = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0000_0000;
        due_q.delete();
        addr_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (4) tick();
        release_rst();
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0000_0000;
        redirect_en = 1'b0; redirect_pc = 32'h0000_0000; stall = 1'b0;

        // Reset values and streaming start-up
        repeat (3) tick();
        #1;
        chk("rst_req", imem_req, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", instr_valid, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_opcode", opcode, 32'h0);
        rst = 1'b0;
        #1; chk("wait_req", imem_req, 32'h0);
        tick(); #1; chk("s1_req", imem_req, 32'h1); chk("s1_addr0", imem_addr, 32'h0);
        tick(); #1; chk("s1_addr4", imem_addr, 32'h4); chk("s1_valid_c2", instr_valid, 32'h0);
        tick(); #1; chk("s1_valid_c3", instr_valid, 32'h1); chk("s1_pc0", instr_pc, 32'h0);
        chk("s1_instr0", instr, 32'hFFFF_FFFF); chk("s1_addr8", imem_addr, 32'h8);
        tick(); #1; chk("s1_pc4", instr_pc, 32'h4); chk("s1_addr12", imem_addr, 32'hC);
        tick(); #1; chk("s1_pc8", instr_pc, 32'h8);

        // Five stall cycles fill the FIFO and throttle requests
        stall = 1'b1; #1;
        chk("st_req_drop", imem_req, 32'h0); chk("st_valid", instr_valid, 32'h1);
        tick(); tick(); #1;
        chk("st_req_full", imem_req, 32'h0); chk("st_pc_hold", instr_pc, 32'h8);
        tick(); tick(); tick();
        stall = 1'b0; #1;
        chk("st_rel_pc8", instr_pc, 32'h8); chk("st_rel_req", imem_req, 32'h1);
        chk("st_rel_addr", imem_addr, 32'h10);
        tick(); #1; chk("st_pc12", instr_pc, 32'hC); chk("st_instr12", instr, 32'hFFFF_FFF3);
        tick(); #1; chk("st_pc16", instr_pc, 32'h10);
        tick(); #1; chk("st_pc20", instr_pc, 32'h14);

        // Redirect with two stale responses in flight (latency 3)
        do_reset(); lat = 3;
        tick();
        tick(); #1; chk("rd_req_r2", imem_req, 32'h1); chk("rd_addr_r2", imem_addr, 32'h4);
        tick(); redirect_en = 1'b1; redirect_pc = 32'h0000_0103; #1;
        chk("rd_credit_block", imem_req, 32'h0);
        tick(); redirect_en = 1'b0; #1;
        chk("rd_tgt_addr", imem_addr, 32'h100); chk("rd_req_r4", imem_req, 32'h0);
        chk("rd_valid_r4", instr_valid, 32'h0);
        tick(); #1; chk("rd_req_r5", imem_req, 32'h1); chk("rd_addr_r5", imem_addr, 32'h100);
        tick(); #1; chk("rd_stale_drop", instr_valid, 32'h0); chk("rd_addr_r6", imem_addr, 32'h104);
        tick(); tick(); #1; chk("rd_valid_r8", instr_valid, 32'h0);
        tick(); #1; chk("rd_valid_r9", instr_valid, 32'h1); chk("rd_pc_r9", instr_pc, 32'h100);
        chk("rd_instr_r9", instr, 32'hFFFF_FEFF); chk("rd_addr_r9", imem_addr, 32'h108);

        // Redirect coincident with a response, a pop and an issue
        redirect_en = 1'b1; redirect_pc = 32'h0000_0200;
        tick(); redirect_en = 1'b0; #1;
        chk("co_valid_r10", instr_valid, 32'h0); chk("co_addr", imem_addr, 32'h200);
        chk("co_req_r10", imem_req, 32'h1);
        tick(); #1; chk("co_valid_r11", instr_valid, 32'h0); chk("co_req_r11", imem_req, 32'h0);
        tick(); #1; chk("co_valid_r12", instr_valid, 32'h0);
        tick(); #1; chk("co_valid_r13", instr_valid, 32'h0);
        tick(); #1; chk("co_valid_r14", instr_valid, 32'h1); chk("co_pc_r14", instr_pc, 32'h200);
        chk("co_instr_r14", instr, 32'hFFFF_FDFF);

        // PC wrap and opcode extraction (latency 1)
        do_reset(); lat = 1;
        tick(); redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick(); redirect_en = 1'b0; #1;
        chk("wr_addr_top", imem_addr, 32'hFFFF_FFFC); chk("wr_req", imem_req, 32'h1);
        tick(); #1; chk("wr_addr_wrap", imem_addr, 32'h0);
        tick(); #1; chk("wr_pc_top", instr_pc, 32'hFFFF_FFFC); chk("wr_instr_top", instr, 32'h3);
        chk("wr_opcode_top", opcode, 32'h0);
        redirect_en = 1'b1; redirect_pc = 32'h0000_0300;
        tick(); redirect_en = 1'b0; #1;
        chk("op_addr", imem_addr, 32'h300); chk("op_valid_r5", instr_valid, 32'h0);
        tick(); #1; chk("op_valid_r6", instr_valid, 32'h0);
        tick(); #1; chk("op_pc", instr_pc, 32'h300); chk("op_instr", instr, 32'hA800_0000);
        chk("op_opcode", opcode, 32'h15);
        tick(); #1; chk("op_pc304", instr_pc, 32'h304); chk("op_opcode304", opcode, 32'h1F);
        lat = 2;
        tick(); tick(); #1; chk("ar_valid_r10", instr_valid, 32'h0);

        // Asynchronous reset mid-stream with two requests outstanding
        rst = 1'b1; #1;
        chk("ar_req", imem_req, 32'h0); chk("ar_addr", imem_addr, 32'h0);
        chk("ar_valid", instr_valid, 32'h0); chk("ar_instr", instr, 32'h0);
        chk("ar_pc", instr_pc, 32'h0); chk("ar_opcode", opcode, 32'h0);
        repeat (4) tick();
        lat = 1;
        release_rst(); #1;
        chk("ar_wait_req", imem_req, 32'h0); chk("ar_wait_valid", instr_valid, 32'h0);
        tick(); #1; chk("ar_restart_req", imem_req, 32'h1); chk("ar_restart_addr", imem_addr, 32'h0);
        tick(); #1; chk("ar_late_ignored", instr_valid, 32'h0);
        tick(); #1; chk("ar_first_valid", instr_valid, 32'h1); chk("ar_first_pc", instr_pc, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage directly upstream of the decoder/control unit. Holds the program counter, issues in-order word requests to instruction memory, and buffers returned words in a small prefetch FIFO. Each buffered word is presented with its PC and extracted 5-bit opcode field to decode. Supports decode back-pressure (stall) and branch redirect with discard of in-flight responses.

## Interface
- ADDR_W, 32, PC/address width
- INSTR_W, 32, instruction width; opcode is bits [INSTR_W-1 -: 5]
- DEPTH, 2, prefetch FIFO entries (power of two, ≥2)
- RESET_PC, 0, PC loaded on reset
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  request valid
- imem_addr  out  ADDR_W  word-aligned request address
- imem_ready  in  1  memory accepts request this cycle (req && ready = issue)
- imem_rvalid  in  1  response valid (in-order, latency ≥1 cycle after issue)
- imem_rdata  in  INSTR_W  response word
- redirect_en  in  1  branch taken/redirect
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored (forced 0)
- stall  in  1  decode cannot accept this cycle
- instr_valid  out  1  FIFO head valid
- instr  out  INSTR_W  FIFO head word
- instr_pc  out  ADDR_W  PC of FIFO head
- opcode  out  5  instr[INSTR_W-1 -: 5], to control unit

## Operation
- Reset values: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, opcode=0, outstanding=0, drop_cnt=0, FIFO empty.
- States: RESET_WAIT (first cycle after rst deasserts, no request) -> RUN. RUN is the only working state; rst from any state returns to RESET_WAIT asynchronously, discarding FIFO, counters, and in-flight tracking.
- Credit rule: imem_req=1 iff state==RUN and occupancy + outstanding - pop < DEPTH, where pop = instr_valid && !stall.
- Issue: pc += 4 (wraps modulo 2^ADDR_W); outstanding += 1. The pc of each issue is pushed into a PC tag queue alongside the data.
- Response: if drop_cnt>0, discard word and decrement drop_cnt; else push {pc_tag, rdata} into FIFO. outstanding -= 1 on every response.
- Pop: the head is consumed when instr_valid && !stall. opcode and instr are combinational from the head. When empty, all outputs read 0.
- Redirect (redirect_en=1):
  - FIFO is cleared, pc = {redirect_pc[ADDR_W-1:2],2'b00}, drop_cnt = outstanding after this cycle's issue/response accounting.
  - Redirect beats a same-cycle pop.
  - A same-cycle response counts as discarded.
  - A same-cycle issue uses the old pc and is counted in drop_cnt.
  - Redirect also applies while stall=1.
- outstanding and drop_cnt never exceed DEPTH; a response with outstanding==0 is a protocol error (assertion).
- Full FIFO: credit rule guarantees no overflow. Simultaneous push and pop on a full FIFO is legal. Simultaneous push and pop on an empty FIFO yields a valid head the next cycle.

## Timing
- First imem_req: second rising edge after rst deasserts.
- Redirect asserted in cycle n: imem_addr=redirect target in cycle n+1; instr_valid=0 in cycle n+1 unless a new response arrives.
- Response in cycle n into an empty FIFO: instr_valid=1 in cycle n+1 (registered FIFO, no bypass).
- Steady state with latency-1 memory, imem_ready=1, and stall=0: one instruction per cycle.
- imem_req/imem_addr are registered-equivalent: stable within a cycle and unchanged while req && !ready, unless a redirect occurs.

## Structure
- Shared package cpu_pkg holds OPCODE_W=5, the opcode field MSB position, the opcode enum consumed by control_unit, and INSTR_W/ADDR_W defaults.
- One sub-module, fetch_fifo: parameterized DEPTH × (ADDR_W+INSTR_W) synchronous FIFO with push, pop, clear, count, and async reset.
- The PC/credit/drop logic and the 2-state FSM live in fetch_stage.

## Test plan
- Reset, RESET_PC=0, memory latency 1, ready=1, stall=0 -> addresses 0,4,8,12 issued on consecutive cycles; instr_valid continuous from cycle 3; instr_pc follows 0,4,8.
- stall held for 5 cycles -> FIFO fills to DEPTH=2; imem_req drops to 0; on release, no word is lost or duplicated, and PCs stay in order.
- Redirect to 0x103 with 2 responses outstanding (latency 3) -> next imem_addr=0x100; the 2 stale words are discarded; first valid instr_pc=0x100.
- Redirect coincident with response and pop -> response discarded; FIFO empty next cycle; the popped word is not re-presented.
- imem_rdata=0xA8000000 -> opcode=5'b10101; pc wrap from 0xFFFFFFFC -> next address 0x00000000.
- rst asserted mid-stream with outstanding requests -> all outputs reach reset values immediately (asynchronously); late responses after reset are ignored; fetch restarts at RESET_PC.
